// File: rtl/dram_timing_responder.sv
// Timed DRAM responder: single open-row model over a DEPTH-word array with
// precharge/activate/access latencies and idle-driven periodic refresh.
module dram_timing_responder #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 256,
  parameter int DEPTH_LOG2 = 12,
  parameter int COL_LOG2   = 5,
  parameter int T_RCD      = 4,
  parameter int T_RP       = 4,
  parameter int T_CAS      = 6,
  parameter int T_WR       = 3,
  parameter int T_REFI     = 512,
  parameter int T_RFC      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              read_en,
  input  logic              write_en,
  input  logic [DATA_W-1:0] wdata,
  output logic              dram_ready,
  output logic              dram_complete,
  output logic [DATA_W-1:0] rdata,
  output logic              valid
);

  localparam int OFFSET = $clog2(DATA_W / 8);
  localparam int ROW_W  = DEPTH_LOG2 - COL_LOG2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_ACT  = 3'd2,
    S_ACC  = 3'd3,
    S_DONE = 3'd4,
    S_REF  = 3'd5
  } state_t;

  function automatic logic [15:0] acc_len(input logic wr);
    return wr ? 16'(T_WR - 1) : 16'(T_CAS - 1);
  endfunction

  logic [DATA_W-1:0]     mem [2**DEPTH_LOG2];

  state_t                state_q, state_d;
  logic [15:0]           timer_q, timer_d;
  logic                  op_wr_q, op_wr_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  row_open_q, row_open_d;
  logic [ROW_W-1:0]      open_row_q, open_row_d;
  logic [31:0]           refi_cnt_q, refi_cnt_d;
  logic                  ref_pend_q, ref_pend_d;
  logic                  ready_q, ready_d;
  logic                  valid_q, valid_d;
  logic                  complete_q, complete_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;

  logic [DEPTH_LOG2-1:0] req_idx_s;
  logic [ROW_W-1:0]      req_row_s;
  logic                  accept_s;

  assign req_idx_s = addr[OFFSET+DEPTH_LOG2-1:OFFSET];
  assign req_row_s = req_idx_s[DEPTH_LOG2-1:COL_LOG2];
  assign accept_s  = ready_q & (read_en | write_en);

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    op_wr_d    = op_wr_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    row_open_d = row_open_q;
    open_row_d = open_row_q;
    refi_cnt_d = refi_cnt_q;
    ref_pend_d = ref_pend_q;
    ready_d    = 1'b0;
    valid_d    = 1'b0;
    complete_d = 1'b0;
    rdata_d    = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (ref_pend_q) begin
          // Pending refresh wins; the busy window began when pending was raised.
          state_d    = S_REF;
          row_open_d = 1'b0;
          timer_d    = (timer_q == 16'd0) ? 16'd0 : timer_q - 16'd1;
        end else if (accept_s) begin
          op_wr_d    = write_en;
          idx_d      = req_idx_s;
          wdata_d    = wdata;
          refi_cnt_d = 32'd0;
          row_open_d = 1'b1;
          open_row_d = req_row_s;
          if (!row_open_q) begin
            state_d = S_ACT;
            timer_d = 16'(T_RCD - 1);
          end else if (open_row_q != req_row_s) begin
            state_d = S_PRE;
            timer_d = 16'(T_RP - 1);
          end else begin
            state_d = S_ACC;
            timer_d = acc_len(write_en);
          end
        end else begin
          ready_d = 1'b1;
          if ((T_REFI != 0) && ((refi_cnt_q + 32'd1) >= 32'(T_REFI))) begin
            ref_pend_d = 1'b1;
            ready_d    = 1'b0;
            timer_d    = 16'(T_RFC - 1);
            refi_cnt_d = refi_cnt_q + 32'd1;
          end else if (T_REFI != 0) begin
            refi_cnt_d = refi_cnt_q + 32'd1;
          end else begin
            refi_cnt_d = 32'd0;
          end
        end
      end
      S_PRE: begin
        if (timer_q == 16'd0) begin
          state_d = S_ACT;
          timer_d = 16'(T_RCD - 1);
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      S_ACT: begin
        if (timer_q == 16'd0) begin
          state_d = S_ACC;
          timer_d = acc_len(op_wr_q);
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      S_ACC: begin
        if (timer_q == 16'd0) begin
          state_d = S_DONE;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      S_DONE: begin
        state_d    = S_IDLE;
        complete_d = 1'b1;
        valid_d    = ~op_wr_q;
        if (!op_wr_q) begin
          rdata_d = mem[idx_q];
        end else begin
          rdata_d = rdata_q;
        end
      end
      S_REF: begin
        if (timer_q == 16'd0) begin
          state_d    = S_IDLE;
          ref_pend_d = 1'b0;
          refi_cnt_d = 32'd0;
          ready_d    = 1'b1;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      timer_q    <= 16'd0;
      op_wr_q    <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      row_open_q <= 1'b0;
      open_row_q <= '0;
      refi_cnt_q <= 32'd0;
      ref_pend_q <= 1'b0;
      ready_q    <= 1'b0;
      valid_q    <= 1'b0;
      complete_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      op_wr_q    <= op_wr_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      row_open_q <= row_open_d;
      open_row_q <= open_row_d;
      refi_cnt_q <= refi_cnt_d;
      ref_pend_q <= ref_pend_d;
      ready_q    <= ready_d;
      valid_q    <= valid_d;
      complete_q <= complete_d;
      rdata_q    <= rdata_d;
    end
  end

  // Array is not reset; the write lands on the DONE edge only.
  always_ff @(posedge clk) begin
    if ((state_q == S_DONE) && op_wr_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign dram_ready    = ready_q;
  assign dram_complete = complete_q;
  assign valid         = valid_q;
  assign rdata         = rdata_q;

endmodule

// File: tb/tb_dram_timing_responder.sv
// Scoreboard bench for dram_timing_responder: the driver queues expected
// completions, a negedge monitor pops and compares them as the DUT reports.
module tb_dram_timing_responder;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [31:0]  addr = 32'd0;
  logic         read_en = 1'b0;
  logic         write_en = 1'b0;
  logic [255:0] wdata = 256'd0;
  logic         dram_ready;
  logic         dram_complete;
  logic [255:0] rdata;
  logic         valid;

  dram_timing_responder dut (
    .clk(clk), .rst(rst), .addr(addr), .read_en(read_en), .write_en(write_en),
    .wdata(wdata), .dram_ready(dram_ready), .dram_complete(dram_complete),
    .rdata(rdata), .valid(valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic         is_rd;
    logic         chk_data;
    logic [255:0] data;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   last_done = 0;
  logic ready_next = 1'b0;

  localparam logic [255:0] PAT_A5 = {32{8'hA5}};
  localparam logic [255:0] PAT_3C = {32{8'h3C}};

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic fail_evt(input string name);
    n_chk++;
    $display("FAIL %s: event seen at cycle %0d, none expected", name, cyc);
  endtask

  // Monitor: every completion is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst) begin
      if (ready_next) begin
        chk("ready_after_done", dram_ready, 1'b1);
        ready_next = 1'b0;
      end
      if (dram_complete) begin
        if (sb.size() == 0) begin
          fail_evt("unexpected_complete");
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("latency", 256'(cyc), 256'(e.due));
          chk("valid_flag", valid, e.is_rd);
          if (e.is_rd && e.chk_data) chk("rdata", rdata, e.data);
          last_done  = cyc;
          ready_next = 1'b1;
        end
      end else if (valid) begin
        fail_evt("valid_without_complete");
      end
    end
  end

  task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [255:0] d, input int lat,
                       input logic chk_data, input logic [255:0] exp_data);
    exp_t e;
    int t = 0;
    while (!dram_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!dram_ready) fail_evt("ready_timeout");
    read_en  = rd;
    write_en = wr;
    addr     = a;
    wdata    = d;
    @(posedge clk);
    #1;
    e.is_rd    = rd & ~wr;
    e.chk_data = chk_data;
    e.data     = exp_data;
    e.due      = cyc + lat;
    sb.push_back(e);
    read_en  = 1'b0;
    write_en = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      fail_evt("complete_timeout");
      sb.delete();
    end
  endtask

  initial begin
    int fall_cyc;
    int low_cnt;
    int seen;
    int t;

    repeat (3) @(negedge clk);
    chk("reset_ready", dram_ready, 1'b0);
    chk("reset_valid", valid, 1'b0);
    chk("reset_complete", dram_complete, 1'b0);
    chk("reset_rdata", rdata, 256'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_first_edge", dram_ready, 1'b1);

    // Write to a closed bank, then a row-hit read of the same word.
    issue(1'b0, 1'b1, 32'h40, PAT_A5, 8, 1'b0, 256'd0);
    wait_done();
    chk("rdata_holds_on_write", rdata, 256'd0);
    issue(1'b1, 1'b0, 32'h40, 256'd0, 7, 1'b1, PAT_A5);
    wait_done();

    // Row 1 while row 0 is open: conflict.
    issue(1'b1, 1'b0, 32'h400, 256'd0, 15, 1'b0, 256'd0);
    wait_done();

    // Back to row 0 (conflict) with stray read pulses while busy.
    issue(1'b1, 1'b0, 32'h40, 256'd0, 15, 1'b1, PAT_A5);
    repeat (2) @(negedge clk);
    read_en = 1'b1;
    addr    = 32'h80;
    repeat (4) @(negedge clk);
    read_en = 1'b0;
    wait_done();

    // Both enables high behaves as a write (row hit).
    issue(1'b1, 1'b1, 32'h80, PAT_3C, 4, 1'b0, 256'd0);
    wait_done();
    issue(1'b1, 1'b0, 32'h80, 256'd0, 7, 1'b1, PAT_3C);
    wait_done();

    // Idle until refresh, measure the busy window, then read a closed row.
    t = 0;
    while (dram_ready && t < 700) begin
      @(negedge clk);
      t++;
    end
    fall_cyc = cyc;
    chk("refresh_start", 256'(fall_cyc), 256'(last_done + 512));
    low_cnt = 0;
    while (!dram_ready && low_cnt < 50) begin
      low_cnt++;
      @(negedge clk);
    end
    chk("refresh_busy_len", 256'(low_cnt), 256'd8);
    issue(1'b1, 1'b0, 32'h80, 256'd0, 11, 1'b1, PAT_3C);
    wait_done();

    // Reset in the middle of a conflict read's access phase.
    issue(1'b1, 1'b0, 32'h400, 256'd0, 15, 1'b0, 256'd0);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    sb.delete();
    chk("midreset_ready", dram_ready, 1'b0);
    chk("midreset_valid", valid, 1'b0);
    chk("midreset_complete", dram_complete, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_midreset", dram_ready, 1'b1);
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (valid || dram_complete) seen++;
    end
    chk("no_response_after_reset", 256'(seen), 256'd0);
    issue(1'b1, 1'b0, 32'h80, 256'd0, 11, 1'b1, PAT_3C);
    wait_done();
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
